// File: rtl/bp_pkg.sv
// Shared types and sizing for the gshare predictor update scheduler.
// One queued update carries the index, resolved direction and mispredict flag.
package bp_pkg;

   localparam int INDEX_W = 6;
   localparam int DEPTH   = 8;
   localparam int DEPTH_W = $clog2(DEPTH);

   typedef struct packed {
      logic [INDEX_W-1:0] pc;
      logic               taken;
      logic               mispredict;
   } bp_upd_t;

endpackage

// File: rtl/bp_update_sched_if.sv
// Commit-side bundle into the scheduler and the predictor modify port out of it.
// The master drives commits and rdy; the slave is the scheduler.
interface bp_update_sched_if;
   import bp_pkg::*;

   logic               rdy;
   logic               c0_valid;
   logic [INDEX_W-1:0] c0_pc;
   logic               c0_taken;
   logic               c0_mispredict;
   logic               c1_valid;
   logic [INDEX_W-1:0] c1_pc;
   logic               c1_taken;
   logic               c1_mispredict;
   logic               in_ready;
   logic               modify_en;
   logic [INDEX_W-1:0] modify_PC;
   logic               choice;
   logic               clear;
   logic               clear_pending;
   logic [DEPTH_W:0]   occupancy;

   modport master (
      output rdy,
      output c0_valid, c0_pc, c0_taken, c0_mispredict,
      output c1_valid, c1_pc, c1_taken, c1_mispredict,
      input  in_ready, modify_en, modify_PC, choice, clear,
      input  clear_pending, occupancy
   );

   modport slave (
      input  rdy,
      input  c0_valid, c0_pc, c0_taken, c0_mispredict,
      input  c1_valid, c1_pc, c1_taken, c1_mispredict,
      output in_ready, modify_en, modify_PC, choice, clear,
      output clear_pending, occupancy
   );

endinterface

// File: rtl/bp_upd_fifo.sv
// Two-write / one-read circular buffer of predictor updates.
// wr1 is only ever asserted together with wr0, so it lands at tail+1.
module bp_upd_fifo
   import bp_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             wr0,
   input  logic             wr1,
   input  bp_upd_t          wd0,
   input  bp_upd_t          wd1,
   input  logic             rd,
   output bp_upd_t          head,
   output logic [DEPTH_W:0] count
);

   bp_upd_t            mem [DEPTH];
   logic [DEPTH_W-1:0] head_ptr;
   logic [DEPTH_W-1:0] tail_ptr;
   logic [DEPTH_W-1:0] tail_nxt;
   logic [1:0]         push_n;

   assign push_n   = {1'b0, wr0} + {1'b0, wr1};
   assign tail_nxt = tail_ptr + DEPTH_W'(1);
   assign head     = mem[head_ptr];

   always_ff @(posedge clk) begin
      if (wr0) mem[tail_ptr] <= wd0;
      if (wr1) mem[tail_nxt] <= wd1;
   end

   // pointers are DEPTH_W bits wide, so wrap modulo DEPTH is free
   always_ff @(posedge clk) begin
      if (rst) begin
         head_ptr <= '0;
         tail_ptr <= '0;
         count    <= '0;
      end else begin
         tail_ptr <= tail_ptr + DEPTH_W'(push_n);
         head_ptr <= head_ptr + DEPTH_W'(rd);
         count    <= count + (DEPTH_W+1)'(push_n)
                           - (DEPTH_W+1)'(rd);
      end
   end

endmodule

// File: rtl/bp_update_sched.sv
// Orders committed branches and feeds the predictor one update per cycle.
// Also flags fetch to hold history insertion while a restore is queued.
module bp_update_sched
   import bp_pkg::*;
(
   input logic               clk,
   input logic               rst,
   bp_update_sched_if.slave  bus
);

   bp_upd_t          head;
   bp_upd_t          wd0;
   bp_upd_t          wd1;
   logic [DEPTH_W:0] count;
   logic [DEPTH_W:0] mcnt;
   logic             push_ok;
   logic             wr0;
   logic             wr1;
   logic             pop;
   logic             live;
   logic             inc;
   logic             dec;

   assign live    = !rst && (count != '0);
   assign push_ok = bus.in_ready;
   assign wr0     = push_ok && bus.c0_valid;
   // a mispredicting c0 makes c1 wrong-path; c1 alone is dropped
   assign wr1     = wr0 && bus.c1_valid && !bus.c0_mispredict;
   assign pop     = bus.modify_en;

   assign wd0 = '{pc: bus.c0_pc, taken: bus.c0_taken,
                  mispredict: bus.c0_mispredict};
   assign wd1 = '{pc: bus.c1_pc, taken: bus.c1_taken,
                  mispredict: bus.c1_mispredict};

   bp_upd_fifo u_fifo (
      .clk   (clk),
      .rst   (rst),
      .wr0   (wr0),
      .wr1   (wr1),
      .wd0   (wd0),
      .wd1   (wd1),
      .rd    (pop),
      .head  (head),
      .count (count)
   );

   assign bus.in_ready  = bus.rdy && !rst &&
                          (count <= (DEPTH_W+1)'(DEPTH-2));
   assign bus.modify_en = bus.rdy && live;
   assign bus.modify_PC = live ? head.pc : '0;
   assign bus.choice    = live && head.taken;
   assign bus.clear     = live && head.mispredict;
   assign bus.occupancy = count;

   assign inc = (wr0 && bus.c0_mispredict) ||
                (wr1 && bus.c1_mispredict);
   assign dec = pop && head.mispredict;

   always_ff @(posedge clk) begin
      if (rst) begin
         mcnt <= '0;
      end else begin
         unique case (1'b1)
            (inc && !dec): mcnt <= mcnt + 1'b1;
            (dec && !inc): mcnt <= mcnt - 1'b1;
            default:       mcnt <= mcnt;
         endcase
      end
   end

   assign bus.clear_pending = (mcnt != '0);

endmodule

// File: tb/tb_bp_update_sched.sv
// Directed bench for bp_update_sched with a queue reference model
// checked every cycle plus hand-computed spot checks.
module tb_bp_update_sched;
   import bp_pkg::*;

   logic clk;
   logic rst;
   int   nchk;
   int   nerr;

   bp_upd_t exp_q[$];

   bp_update_sched_if bus ();

   bp_update_sched dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      nchk++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_model();
      logic e_en;
      logic e_ir;
      logic e_cp;
      bp_upd_t h;
      h    = '0;
      e_cp = 1'b0;
      if (exp_q.size() != 0) h = exp_q[0];
      foreach (exp_q[i]) if (exp_q[i].mispredict) e_cp = 1'b1;
      e_en = bus.rdy && !rst && (exp_q.size() != 0);
      e_ir = bus.rdy && !rst && (exp_q.size() <= DEPTH - 2);
      chk("m_in_ready", 32'(bus.in_ready), 32'(e_ir));
      chk("m_modify_en", 32'(bus.modify_en), 32'(e_en));
      chk("m_modify_PC", 32'(bus.modify_PC), 32'(h.pc));
      chk("m_choice", 32'(bus.choice), 32'(h.taken));
      chk("m_clear", 32'(bus.clear), 32'(h.mispredict));
      chk("m_occupancy", 32'(bus.occupancy), 32'(exp_q.size()));
      chk("m_clear_pending", 32'(bus.clear_pending), 32'(e_cp));
   endtask

   task automatic cyc(input logic v0, input logic [7:0] p0,
                      input logic t0, input logic m0,
                      input logic v1, input logic [7:0] p1,
                      input logic t1, input logic m1);
      logic ir;
      bus.c0_valid      = v0;
      bus.c0_pc         = p0[INDEX_W-1:0];
      bus.c0_taken      = t0;
      bus.c0_mispredict = m0;
      bus.c1_valid      = v1;
      bus.c1_pc         = p1[INDEX_W-1:0];
      bus.c1_taken      = t1;
      bus.c1_mispredict = m1;
      @(posedge clk);
      if (rst) begin
         exp_q.delete();
      end else if (bus.rdy) begin
         ir = (exp_q.size() <= DEPTH - 2);
         if (exp_q.size() != 0) void'(exp_q.pop_front());
         if (ir && v0) begin
            exp_q.push_back('{p0[INDEX_W-1:0], t0, m0});
            if (v1 && !m0) exp_q.push_back('{p1[INDEX_W-1:0], t1, m1});
         end
      end
      #1;
      bus.c0_valid = 1'b0;
      bus.c1_valid = 1'b0;
      check_model();
   endtask

   task automatic idle();
      cyc(0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      nchk = 0;
      nerr = 0;
      rst  = 1'b1;
      bus.rdy = 1'b1;
      bus.c0_valid = 0; bus.c0_pc = '0; bus.c0_taken = 0;
      bus.c0_mispredict = 0;
      bus.c1_valid = 0; bus.c1_pc = '0; bus.c1_taken = 0;
      bus.c1_mispredict = 0;

      idle();
      chk("rst_in_ready", 32'(bus.in_ready), 0);
      chk("rst_modify_en", 32'(bus.modify_en), 0);
      chk("rst_occupancy", 32'(bus.occupancy), 0);
      chk("rst_clear_pending", 32'(bus.clear_pending), 0);
      rst = 1'b0;
      #1;
      chk("post_rst_in_ready", 32'(bus.in_ready), 1);

      // single push, one-cycle latency, no bypass
      cyc(1, 8'h05, 1, 0, 0, 0, 0, 0);
      chk("t1_en", 32'(bus.modify_en), 1);
      chk("t1_pc", 32'(bus.modify_PC), 32'h05);
      chk("t1_choice", 32'(bus.choice), 1);
      chk("t1_clear", 32'(bus.clear), 0);
      idle();
      chk("t1_en_after", 32'(bus.modify_en), 0);
      chk("t1_occ_after", 32'(bus.occupancy), 0);

      // dual push, program order
      cyc(1, 8'h01, 1, 0, 1, 8'h02, 0, 0);
      chk("t2_pc0", 32'(bus.modify_PC), 32'h01);
      chk("t2_occ", 32'(bus.occupancy), 2);
      idle();
      chk("t2_pc1", 32'(bus.modify_PC), 32'h02);
      chk("t2_choice1", 32'(bus.choice), 0);
      idle();
      chk("t2_en_end", 32'(bus.modify_en), 0);

      // mispredict on c0 discards c1
      cyc(1, 8'h03, 0, 1, 1, 8'h3f, 1, 0);
      chk("t3_occ", 32'(bus.occupancy), 1);
      chk("t3_cp", 32'(bus.clear_pending), 1);
      chk("t3_pc", 32'(bus.modify_PC), 32'h03);
      chk("t3_clear", 32'(bus.clear), 1);
      idle();
      chk("t3_cp_after", 32'(bus.clear_pending), 0);
      chk("t3_occ_after", 32'(bus.occupancy), 0);

      // rdy low freezes everything
      cyc(1, 8'h10, 1, 0, 1, 8'h11, 0, 0);
      cyc(1, 8'h12, 1, 0, 1, 8'h13, 1, 0);
      chk("t4_occ", 32'(bus.occupancy), 3);
      bus.rdy = 1'b0;
      #1;
      chk("t4_en_hold", 32'(bus.modify_en), 0);
      chk("t4_ir_hold", 32'(bus.in_ready), 0);
      for (int i = 0; i < 5; i++) begin
         cyc(1, 8'h3e, 1, 0, 0, 0, 0, 0);
         chk("t4_occ_hold", 32'(bus.occupancy), 3);
      end
      bus.rdy = 1'b1;
      #1;
      chk("t4_pc_a", 32'(bus.modify_PC), 32'h11);
      idle();
      chk("t4_pc_b", 32'(bus.modify_PC), 32'h12);
      idle();
      chk("t4_pc_c", 32'(bus.modify_PC), 32'h13);
      idle();
      chk("t4_en_end", 32'(bus.modify_en), 0);

      // fill to DEPTH-1 then offer a push that must be dropped
      for (int i = 0; i < 6; i++)
         cyc(1, 8'(8'h20 + 2 * i), 1, 0, 1, 8'(8'h21 + 2 * i), 0, 0);
      chk("t5_occ_full", 32'(bus.occupancy), 7);
      chk("t5_ir_full", 32'(bus.in_ready), 0);
      cyc(1, 8'h3a, 1, 1, 1, 8'h3b, 0, 0);
      chk("t5_occ_drop", 32'(bus.occupancy), 6);
      chk("t5_cp_drop", 32'(bus.clear_pending), 0);
      for (int i = 0; i < 6; i++) idle();
      chk("t5_en_end", 32'(bus.modify_en), 0);

      // random traffic across wrap-around
      for (int i = 0; i < 20; i++)
         cyc(1'($urandom_range(0, 3) != 0), 8'($urandom),
             1'($urandom), 1'($urandom_range(0, 3) == 0),
             1'($urandom), 8'($urandom),
             1'($urandom), 1'($urandom_range(0, 3) == 0));
      for (int i = 0; i < 10; i++) idle();
      chk("t6_empty", 32'(bus.occupancy), 0);

      // reset mid-operation
      cyc(1, 8'h31, 1, 0, 1, 8'h32, 0, 0);
      cyc(1, 8'h33, 0, 0, 1, 8'h34, 1, 1);
      cyc(1, 8'h35, 1, 0, 1, 8'h36, 0, 0);
      cyc(1, 8'h37, 1, 0, 1, 8'h38, 0, 0);
      chk("t7_occ", 32'(bus.occupancy), 5);
      chk("t7_cp", 32'(bus.clear_pending), 1);
      rst = 1'b1;
      idle();
      chk("t7_occ_rst", 32'(bus.occupancy), 0);
      chk("t7_en_rst", 32'(bus.modify_en), 0);
      chk("t7_cp_rst", 32'(bus.clear_pending), 0);
      rst = 1'b0;
      idle();
      chk("t7_ir_after", 32'(bus.in_ready), 1);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
